div_ctrl: RTL
=============

Name: div_ctrl

Overview:
- Sequencing controller between the EX stage and the iterative 32-bit divider (start/annul/ready handshake, result {remainder, quotient}).
- Accepts DIV/DIVU from EX, latches operands, and holds divider start until ready.
- Raises a pipeline stall request while the divide runs, buffers HI/LO until EX advances, and handles flushes without leaving the divider in a stale state.

Parameters:
DRAIN_CYCLES, 2, cycles with start low after an annul before a new start may issue; covers the divider's by-zero→end→free path.
CNT_W, 2, width of the drain counter; must hold DRAIN_CYCLES.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
div_req_i  in  1  EX holds a valid DIV/DIVU
signed_i  in  1  1=DIV (signed), 0=DIVU
op1_i  in  32  dividend
op2_i  in  32  divisor
ex_stall_i  in  1  downstream stall; EX does not advance this cycle
flush_i  in  1  exception/flush; kills the EX instruction
div_result_i  in  64  from divider: [63:32] remainder, [31:0] quotient
div_ready_i  in  1  from divider
div_start_o  out  1  to divider start_i
div_annul_o  out  1  to divider annul_i
div_signed_o  out  1  latched signed_i
div_op1_o  out  32  latched op1
div_op2_o  out  32  latched op2
stall_req_o  out  1  to hazard unit
hilo_we_o  out  1  HI/LO write strobe
hi_o  out  32  remainder
lo_o  out  32  quotient
div_zero_o  out  1  latched (op2==0), valid with hilo_we_o

Behaviour:
- Reset (rst=0, async): state IDLE. All registered outputs 0, drain counter 0.
- IDLE:
  - If div_req_i && !flush_i: latch signed/op1/op2/zero flag, set div_start_o=1 at next edge, go BUSY.
  - stall_req_o = div_req_i && !flush_i (combinational), so the stall starts the same cycle.
- BUSY:
  - div_start_o held 1; stall_req_o=1.
  - If flush_i: div_start_o←0, div_annul_o←1 for exactly one cycle, counter←DRAIN_CYCLES, go DRAIN. Flush beats a same-cycle div_ready_i; the result is discarded.
  - Else if div_ready_i: hi/lo←div_result_i, div_start_o←0, go DONE.
  - Operands stay stable regardless of op1_i/op2_i changes.
- DONE:
  - div_start_o=0; stall_req_o=0; result held.
  - hilo_we_o = !ex_stall_i && !flush_i (Mealy).
  - If flush_i: go IDLE, no write.
  - Else if !ex_stall_i: write fires, go IDLE.
  - Else stay; the request is never re-issued while EX is frozen.
- DRAIN:
  - start=0, stall_req_o = div_req_i. Counter decrements; at 0 go IDLE.
  - Requests arriving during DRAIN wait; there is no lost-request path.
- Divider latency is taken from div_ready_i only (≈35 cycles); the controller hard-codes no count.
- Back-to-back: a new start is never registered earlier than 2 cycles after DONE entry, which guarantees the divider has left its end state. Minimum gap between div_start_o deassert and re-assert is 2 cycles.
- Divide-by-zero: divider returns 0. Controller passes hi=lo=0 with div_zero_o=1.
- div_annul_o is never 1 outside the cycle after a BUSY flush.
- Reset mid-operation aborts immediately; the divider is reset by its own reset.
- State encoding: 2 bits. IDLE=00, BUSY=01, DONE=10, DRAIN=11.

Decomposition:
- Shared defines header holds the state constants (DivCtrlIdle/Busy/Done/Drain) and the DRAIN_CYCLES default.
- No sub-module. The divider is instantiated beside this block in the EX stage, not inside it.

Test Plan:
- DIVU 100/7 → stall_req_o 1 until ready; hilo_we_o one cycle with hi=2, lo=14, div_zero_o=0.
- DIV 0xFFFFFF9C(-100)/7 → lo=0xFFFFFFF2, hi=0xFFFFFFFE.
- DIVU 5/0 → hi=lo=0, div_zero_o=1, single write.
- Flush 10 cycles after start → div_annul_o one-cycle pulse, no hilo_we_o, start low ≥2 cycles. Next DIVU 9/2 gives hi=1, lo=4.
- ex_stall_i held 5 cycles in DONE → hi/lo stable, hilo_we_o 0, no second div_start_o. Release → exactly one write.
- Two back-to-back DIVUs (81/9, then 7/3) → writes lo=9,hi=0 then lo=2,hi=1. Async rst low mid-BUSY → all outputs 0 with no clock edge.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg
//   Shared definitions for the EX-stage divider sequencing controller:
//   the 2-bit state encoding and the default drain length after an annul.
package div_ctrl_pkg;

  // Number of cycles div_start_o is held low after an annul before a new
  // start may issue. Long enough for the divider to walk its
  // by-zero -> end -> free path and return to idle.
  localparam int DRAIN_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    DivCtrlIdle  = 2'b00,
    DivCtrlBusy  = 2'b01,
    DivCtrlDone  = 2'b10,
    DivCtrlDrain = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl
//   Sequencing controller between the EX stage and the iterative 32-bit
//   divider. Latches DIV/DIVU operands, holds divider start until ready,
//   requests a pipeline stall while the divide runs, buffers HI/LO until EX
//   advances, and annuls/drains the divider on a flush.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   div_req_i         EX holds a valid DIV/DIVU
//   signed_i          1 = DIV, 0 = DIVU
//   op1_i, op2_i      dividend, divisor
//   ex_stall_i        EX frozen this cycle (downstream stall)
//   flush_i           kill the EX instruction
//   div_result_i      divider result {remainder, quotient}
//   div_ready_i       divider result valid
//   div_start_o       divider start (held until ready)
//   div_annul_o       divider annul, one-cycle pulse after a BUSY flush
//   div_signed_o      latched signed flag
//   div_op1_o/op2_o   latched operands
//   stall_req_o       stall request to the hazard unit
//   hilo_we_o         HI/LO write strobe
//   hi_o, lo_o        remainder, quotient
//   div_zero_o        latched (divisor == 0), valid with hilo_we_o
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        ex_stall_i,
  input  logic        flush_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        stall_req_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  div_state_e        state_q, state_d;
  logic              start_q, start_d;
  logic              annul_q, annul_d;
  logic              signed_q, signed_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;
  logic              zero_q, zero_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall_c;
  logic              we_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivCtrlIdle;
      start_q  <= 1'b0;
      annul_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    annul_d  = 1'b0;         // annul is only ever a single-cycle pulse
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    we_c     = 1'b0;

    unique case (state_q)
      DivCtrlIdle: begin
        // Stall combinationally so EX freezes in the same cycle it presents
        // the divide, before the start is even registered.
        stall_c = div_req_i && !flush_i;
        if (div_req_i && !flush_i) begin
          signed_d = signed_i;
          op1_d    = op1_i;
          op2_d    = op2_i;
          zero_d   = (op2_i == 32'd0);
          start_d  = 1'b1;
          state_d  = DivCtrlBusy;
        end
      end

      DivCtrlBusy: begin
        stall_c = 1'b1;
        start_d = 1'b1;
        // Flush wins over a coincident ready: the result belongs to a
        // killed instruction and the divider must be annulled either way.
        if (flush_i) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          cnt_d   = CNT_W'(DRAIN_CYCLES);
          state_d = DivCtrlDrain;
        end else if (div_ready_i) begin
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          start_d = 1'b0;
          state_d = DivCtrlDone;
        end
      end

      DivCtrlDone: begin
        start_d = 1'b0;
        // Result is held here while EX is frozen; leaving only through
        // IDLE guarantees at least two start-low cycles before a restart.
        we_c = !ex_stall_i && !flush_i;
        if (flush_i || !ex_stall_i) begin
          state_d = DivCtrlIdle;
        end
      end

      DivCtrlDrain: begin
        start_d = 1'b0;
        stall_c = div_req_i;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = DivCtrlIdle;
        end
      end

      default: begin
        state_d = DivCtrlIdle;
      end
    endcase
  end

  assign div_start_o  = start_q;
  assign div_annul_o  = annul_q;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign div_zero_o   = zero_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  // Combinational strobes are forced quiet while reset is asserted so every
  // output reads 0 during reset without waiting for a clock edge.
  assign stall_req_o  = rst && stall_c;
  assign hilo_we_o    = rst && we_c;

endmodule
